// File: rtl/basic_and_arb_pkg.sv
// rtl/basic_and_arb_pkg.sv - shared state type and sizing helpers for basic_and_arbiter
package basic_and_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  localparam int HOLD_W = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/basic_and_arbiter_if.sv
// rtl/basic_and_arbiter_if.sv - requester, response and cell signals of basic_and_arbiter
interface basic_and_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import basic_and_arb_pkg::*;

  localparam int IDX_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_a;
  logic [NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_valid;
  logic               rsp_data;
  logic [NUM_REQ-1:0] rsp_ready;
  logic               cell_a;
  logic               cell_b;
  logic               cell_out;
  logic [IDX_W-1:0]   grant_idx;
  logic               busy;
  logic [15:0]        done_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, cell_out,
    input  req_ready, rsp_valid, rsp_data, cell_a, cell_b, grant_idx, busy, done_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, cell_out,
    output req_ready, rsp_valid, rsp_data, cell_a, cell_b, grant_idx, busy, done_count
  );

endinterface

// File: rtl/basic_and_arbiter_picker.sv
// rtl/basic_and_arbiter_picker.sv - cyclic first-set search over req_valid starting at rr_ptr
module and_rr_picker
  import basic_and_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               hit,
  output logic [IDX_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  logic [IDX_W:0]       offset;
  logic [IDX_W:0]       sum;

  // Rotating right by rr_ptr turns the cyclic search into a plain lowest-set-bit search.
  always_comb begin
    doubled = {req_valid, req_valid};
    rotated = NUM_REQ'(doubled >> rr_ptr);
    hit     = |rotated;
    offset  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = (IDX_W+1)'(i);
    end
    sum = {1'b0, rr_ptr} + offset;
    if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/basic_and_arbiter.sv
// rtl/basic_and_arbiter.sv - round-robin sequencer sharing one basic_and cell among requesters
module basic_and_arbiter
  import basic_and_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 1
) (
  input logic               clk,
  input logic               rst_n,
  basic_and_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_t         state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_hit;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic               rsp_data_q;
  logic               cell_a_q;
  logic               cell_b_q;
  logic               busy_q;
  logic [15:0]        done_q;

  and_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .hit       (pick_hit),
    .idx       (pick_idx)
  );

  // Accept must land in the same IDLE cycle the operands are registered, so it stays
  // combinational; rst_n gating keeps it silent while reset is held.
  assign bus.req_ready = (rst_n && state == IDLE && pick_hit) ? (NUM_REQ'(1) << pick_idx) : '0;

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.cell_a     = cell_a_q;
  assign bus.cell_b     = cell_b_q;
  assign bus.grant_idx  = grant_q;
  assign bus.busy       = busy_q;
  assign bus.done_count = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      rr_ptr      <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= 1'b0;
      cell_a_q    <= 1'b0;
      cell_b_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_hit) begin
            cell_a_q <= bus.req_a[pick_idx];
            cell_b_q <= bus.req_b[pick_idx];
            grant_q  <= pick_idx;
            hold_cnt <= HOLD_W'(HOLD_CYCLES);
            busy_q   <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt == HOLD_W'(1)) state <= CAPTURE;
        end
        CAPTURE: begin
          // cell_out already reflects the operands registered at the last HOLD edge.
          rsp_data_q  <= bus.cell_out;
          rsp_valid_q <= NUM_REQ'(1) << grant_q;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[grant_q]) begin
            rsp_valid_q <= '0;
            done_q      <= done_q + 16'd1;
            rr_ptr      <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_basic_and_arbiter.sv
// tb/tb_basic_and_arbiter.sv - directed scoreboard bench for basic_and_arbiter
`timescale 1ns/1ps
module tb_basic_and_arbiter;

  typedef struct {
    int   idx;
    logic d;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sel;
  logic [3:0] rv, ra, rb, rr;
  logic       c1 = 1'b0;
  logic       c5 = 1'b0;
  logic       d;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];

  basic_and_arbiter_if #(.NUM_REQ(4)) bus1 ();
  basic_and_arbiter_if #(.NUM_REQ(4)) bus5 ();

  basic_and_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  basic_and_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  assign bus1.req_valid = sel ? 4'b0 : rv;
  assign bus5.req_valid = sel ? rv : 4'b0;
  assign bus1.req_a     = ra;
  assign bus5.req_a     = ra;
  assign bus1.req_b     = rb;
  assign bus5.req_b     = rb;
  assign bus1.rsp_ready = rr;
  assign bus5.rsp_ready = rr;

  // Shared basic_and cells: registered AND of the driven operands.
  always @(posedge clk) begin
    c1 <= bus1.cell_a & bus1.cell_b;
    c5 <= bus5.cell_a & bus5.cell_b;
  end
  assign bus1.cell_out = c1;
  assign bus5.cell_out = c5;

  logic [3:0]  o_rr, o_rv;
  logic        o_rd, o_ca, o_cb, o_busy;
  logic [1:0]  o_gi;
  logic [15:0] o_done;
  assign o_rr   = sel ? bus5.req_ready  : bus1.req_ready;
  assign o_rv   = sel ? bus5.rsp_valid  : bus1.rsp_valid;
  assign o_rd   = sel ? bus5.rsp_data   : bus1.rsp_data;
  assign o_ca   = sel ? bus5.cell_a     : bus1.cell_a;
  assign o_cb   = sel ? bus5.cell_b     : bus1.cell_b;
  assign o_gi   = sel ? bus5.grant_idx  : bus1.grant_idx;
  assign o_busy = sel ? bus5.busy       : bus1.busy;
  assign o_done = sel ? bus5.done_count : bus1.done_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int first_one(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // One transaction on the selected DUT: accept, hold window, response check.
  task automatic do_txn(input int exp_g, input int hold, input bit drop, output logic dout);
    int   g;
    int   lat;
    logic ea, eb;
    exp_t e;
    g = -1;
    dout = 1'b0;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (o_rr != 4'b0) begin
        g = first_one(o_rr);
        break;
      end
      @(negedge clk);
    end
    check("accept_seen", (g >= 0) ? 32'd1 : 32'd0, 32'd1);
    if (g < 0) return;
    check("grant_order", g, exp_g);
    check("req_ready_onehot", o_rr, 32'd1 << g);
    ea = ra[g];
    eb = rb[g];
    sb.push_back('{idx: g, d: ea & eb});
    @(posedge clk); #1;
    if (drop) begin
      rv[g] = 1'b0;
      ra[g] = ~ra[g];
      rb[g] = ~rb[g];
    end
    @(negedge clk);
    check("req_ready_pulse", o_rr, 0);
    check("busy_after_accept", o_busy, 1);
    lat = 1;
    while (o_rv == 4'b0 && lat < 40) begin
      check("cell_a_stable", o_ca, ea);
      check("cell_b_stable", o_cb, eb);
      @(negedge clk);
      lat++;
    end
    check("rsp_latency", lat, hold + 2);
    e = sb.pop_front();
    check("rsp_valid_onehot", o_rv, 32'd1 << e.idx);
    check("rsp_data", o_rd, e.d);
    check("grant_idx", o_gi, e.idx);
    dout = e.d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; rv = '0; ra = '0; rb = '0; rr = 4'hF; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {o_rr, o_rv, o_rd, o_ca, o_cb, o_gi, o_busy, o_done}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {o_rr, o_rv, o_rd, o_ca, o_cb, o_gi, o_busy, o_done}, 0);

    // Single request
    rv = 4'b0001; ra = 4'b0001; rb = 4'b0001;
    do_txn(0, 1, 1'b1, d);
    @(negedge clk);
    check("single_done", o_done, 1);
    check("single_idle", {o_busy, o_rv}, 0);

    // Round robin from a fresh pointer
    do_reset();
    rv = 4'hF; ra = 4'b1101; rb = 4'b1011;
    for (int k = 0; k < 5; k++) do_txn(k % 4, 1, 1'b0, d);
    rv = 4'b0;
    @(negedge clk);
    check("rr_done", o_done, 5);

    // Response backpressure on requester 2
    rr = 4'b1011; rv = 4'hF;
    do_txn(1, 1, 1'b0, d);
    do_txn(2, 1, 1'b0, d);
    for (int c = 0; c < 10; c++) begin
      check("bp_rsp_valid", o_rv, 4'b0100);
      check("bp_rsp_data", o_rd, d);
      check("bp_no_accept", o_rr, 0);
      check("bp_busy", o_busy, 1);
      @(negedge clk);
    end
    rr = 4'hF; rv = 4'b0;
    @(negedge clk);
    check("bp_done", o_done, 7);
    check("bp_idle", o_busy, 0);

    // Hold window of 5 after a prior 1,1
    sel = 1'b1;
    rv = 4'b0001; ra = 4'b0001; rb = 4'b0001;
    do_txn(0, 5, 1'b1, d);
    rv = 4'b0001; ra = 4'b0001; rb = 4'b0000;
    do_txn(0, 5, 1'b1, d);
    rv = 4'b0;
    @(negedge clk);
    check("hold_done", o_done, 2);
    sel = 1'b0;

    // Reset during HOLD, rr_ptr sits at 3 beforehand
    rv = 4'b1110; ra = 4'hF; rb = 4'hF;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (o_rr != 4'b0) break;
      @(negedge clk);
    end
    check("pre_reset_grant", o_rr, 4'b1000);
    @(posedge clk); #2;
    check("pre_reset_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {o_rr, o_rv, o_rd, o_ca, o_cb, o_gi, o_busy, o_done}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_held_outputs", {o_rr, o_rv, o_rd, o_ca, o_cb, o_gi, o_busy, o_done}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    do_txn(1, 1, 1'b0, d);
    rv = 4'b0;
    @(negedge clk);
    check("post_reset_done", o_done, 1);

    // Counter wrap
    force dut1.done_q = 16'hFFFF;
    @(negedge clk);
    release dut1.done_q;
    #1;
    check("preload_done", o_done, 16'hFFFF);
    rv = 4'b0001; ra = 4'b0001; rb = 4'b0000;
    do_txn(0, 1, 1'b1, d);
    @(negedge clk);
    check("done_wrap", o_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/basic_and_arbiter.md
# basic_and_arbiter

Round-robin arbiter and sequencer that shares one `basic_and` cell among `NUM_REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the pair onto the cell's `a`/`b` inputs. It holds them stable across a programmable number of cell clock edges, captures `out`, and returns the result to the granting requester. It sits directly in front of `basic_and` in the same clock domain and guarantees clean, timing-checkable input windows for the cell.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters; legal range 2..8.
- `HOLD_CYCLES`, 1, clock edges the cell inputs stay stable before capture; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge; also clocks the shared `basic_and`.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_a`  in  NUM_REQ  per-requester operand a.
- `req_b`  in  NUM_REQ  per-requester operand b.
- `req_ready`  out  NUM_REQ  one-hot accept pulse.
- `rsp_valid`  out  NUM_REQ  one-hot result valid.
- `rsp_data`  out  1  result bit, shared by all requesters.
- `rsp_ready`  in  NUM_REQ  per-requester result accept.
- `cell_a`  out  1  drives `basic_and` `a`.
- `cell_b`  out  1  drives `basic_and` `b`.
- `cell_out`  in  1  from `basic_and` `out`.
- `grant_idx`  out  clog2(NUM_REQ)  index of the current or last grant.
- `busy`  out  1  high in every state except IDLE.
- `done_count`  out  16  completed transactions; wraps 0xFFFF→0.

## Operation
- States are IDLE, HOLD, CAPTURE, RESP.
- **IDLE**
  - If any `req_valid` is high, pick the first set bit at or after `rr_ptr`, searching cyclically.
  - Assert `req_ready[g]` for exactly this cycle.
  - Register `cell_a`/`cell_b` from `req_a[g]`/`req_b[g]`, set `grant_idx=g`, load `hold_cnt=HOLD_CYCLES`, and go to HOLD.
- **HOLD**
  - `cell_a`/`cell_b` are frozen.
  - Decrement `hold_cnt` each cycle. At 1, go to CAPTURE.
- **CAPTURE**
  - Register `rsp_data <= cell_out`, which is the cell's value registered at the last HOLD edge.
  - Go to RESP.
- **RESP**
  - Hold `rsp_valid[g]=1` and `rsp_data` stable until `rsp_ready[g]`.
  - On the handshake: set `rr_ptr=(g+1) mod NUM_REQ`, increment `done_count`, and go to IDLE.
- `cell_a`/`cell_b` keep their last values in IDLE and are not zeroed, so no spurious edges reach the cell.
- `req_valid` of a non-granted requester has no effect outside IDLE; the requester must hold its request until it is accepted.
- `rsp_ready` while the matching `rsp_valid` is low is ignored.
- A new request during RESP is never accepted in the same cycle as the response handshake; it is accepted in IDLE at the earliest on the next cycle.
- Requester operands are not sampled after the accept cycle.

## Timing
- Reset (`rst_n` low, asynchronous) forces:
  - state=IDLE.
  - All outputs 0: `req_ready`, `rsp_valid`, `rsp_data`, `cell_a`, `cell_b`, `grant_idx`, `busy`, `done_count`.
  - `rr_ptr=0`.
- Reset mid-transaction drops the transaction. No response is issued and `done_count` is unchanged from 0.
- Timeline relative to the accept edge T, with a zero-wait consumer:
  - Cell inputs change at T.
  - Cell registers at edges T+1..T+HOLD_CYCLES.
  - `rsp_data` is valid from T+HOLD_CYCLES+1.
  - IDLE resumes at T+HOLD_CYCLES+2.
- Minimum request-to-request period is HOLD_CYCLES+3 cycles, i.e. 4 cycles when HOLD_CYCLES=1.
- `busy` rises the cycle after accept and falls the cycle after the response handshake.

## Structure
- Package `basic_and_arb_pkg` holds:
  - The state enum (IDLE, HOLD, CAPTURE, RESP).
  - The `IDX_W = clog2(NUM_REQ)` helper.
  - The `HOLD_W=4` counter width constant.
- One natural sub-module, `and_rr_picker`: combinational cyclic first-set search over `req_valid` from `rr_ptr`. It outputs a hit flag and an index.
- The top instantiates the picker and the FSM. It does not instantiate `basic_and`; the testbench connects the cell.

## Test plan
1. **Single request:** reset, then `req_valid=0001`, a=1, b=1, HOLD_CYCLES=1.
   - `req_ready=0001` for 1 cycle.
   - `cell_a`/`cell_b`=1.
   - `rsp_valid[0]` is high 3 cycles after accept with `rsp_data=1`.
   - `done_count=1`.
2. **Round-robin:** `req_valid=1111` held continuously with distinct operands.
   - Grant order is 0,1,2,3,0.
   - `rsp_data` equals a&b of each granted requester.
3. **Response backpressure:** `rsp_ready[2]` held low for 10 cycles.
   - `rsp_valid[2]` and `rsp_data` stay stable.
   - No `req_ready` asserts and `busy=1` throughout.
4. **Hold window:** HOLD_CYCLES=5 with a=1, b=0 after a prior 1,1.
   - `cell_a`/`cell_b` are stable for 5 edges.
   - `rsp_data=0`.
5. **Reset mid-HOLD:** assert `rst_n=0` during HOLD.
   - All outputs are 0 immediately (asynchronously), with no response issued.
   - After release, the first grant goes to the lowest valid index.
6. **Counter wrap:** preload via 65535 transactions (or force).
   - The next completion sets `done_count=0`.
